// File: rtl/i2c_eeprom_master.sv
// i2c_eeprom_master: byte-level I2C master for 24Cxx EEPROMs (8-bit word address).
// Runs at 4x the SCL rate; every bus element (START, RESTART, STOP, bit) is four
// clocks long (ph0..ph3). One single-byte write or one random read per request.
//
// Request handshake: start is looked at only while the FSM is idle; the cycle it is
// seen high, rw/dev_addr/mem_addr/wr_data are captured and ack_error is cleared.
// busy is high from the first START cycle to the last STOP cycle, then done pulses
// for exactly one cycle (busy low). A start seen while busy or during done is dropped.
module i2c_eeprom_master (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] mem_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX_DEVW,
        ST_TX_MADDR,
        ST_TX_DATA,
        ST_RESTART,
        ST_TX_DEVR,
        ST_RX_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_phase;
    logic [3:0]  r_bit;        // 0..7 data bits, 8 = acknowledge bit
    logic        r_rw;
    logic [6:0]  r_dev;
    logic [7:0]  r_mem;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rx;
    logic        r_sda_smp;    // sda_in captured at ph2 of the current bit
    logic [7:0]  r_rd_data;
    logic        r_busy;
    logic        r_done;
    logic        r_ack_error;
    logic        r_scl;
    logic        r_sda_oe;

    state_t      w_state_nxt;
    logic [1:0]  w_phase_nxt;
    logic [3:0]  w_bit_nxt;
    logic        w_nack;
    logic [7:0]  w_tx_byte;
    logic [2:0]  w_bit_idx;
    logic        w_mid;
    logic        w_scl_nxt;
    logic        w_sda_oe_nxt;
    logic        w_in_byte;

    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_error = r_ack_error;
    assign scl       = r_scl;
    assign sda_oe    = r_sda_oe;

    assign w_in_byte = (r_state == ST_TX_DEVW) || (r_state == ST_TX_MADDR) ||
                       (r_state == ST_TX_DATA) || (r_state == ST_TX_DEVR)  ||
                       (r_state == ST_RX_DATA);

    // Next state/phase/bit: elements end at ph3; a slave NACK diverts to STOP.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 2'd1;
        w_bit_nxt   = r_bit;
        w_nack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = 2'd0;
                w_bit_nxt   = 4'd0;
                if (start) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DONE: begin
                w_phase_nxt = 2'd0;
                w_bit_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                if (r_phase == 2'd3) begin
                    case (r_state)
                        ST_START: begin
                            w_state_nxt = ST_TX_DEVW;
                            w_bit_nxt   = 4'd0;
                        end
                        ST_RESTART: begin
                            w_state_nxt = ST_TX_DEVR;
                            w_bit_nxt   = 4'd0;
                        end
                        ST_STOP: begin
                            w_state_nxt = ST_DONE;
                        end
                        default: begin
                            if (r_bit != 4'd8) begin
                                w_bit_nxt = r_bit + 4'd1;
                            end else begin
                                w_bit_nxt = 4'd0;
                                if ((r_state != ST_RX_DATA) && r_sda_smp) begin
                                    w_nack      = 1'b1;
                                    w_state_nxt = ST_STOP;
                                end else begin
                                    case (r_state)
                                        ST_TX_DEVW:  w_state_nxt = ST_TX_MADDR;
                                        ST_TX_MADDR: w_state_nxt = r_rw ? ST_RESTART : ST_TX_DATA;
                                        ST_TX_DEVR:  w_state_nxt = ST_RX_DATA;
                                        default:     w_state_nxt = ST_STOP;
                                    endcase
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Bus line levels for the upcoming element/phase, so scl/sda_oe can be registered.
    always_comb begin
        case (w_state_nxt)
            ST_TX_DEVW:  w_tx_byte = {r_dev, 1'b0};
            ST_TX_MADDR: w_tx_byte = r_mem;
            ST_TX_DATA:  w_tx_byte = r_wdata;
            ST_TX_DEVR:  w_tx_byte = {r_dev, 1'b1};
            default:     w_tx_byte = 8'h00;
        endcase
        w_bit_idx    = 3'd7 - w_bit_nxt[2:0];
        w_mid        = (w_phase_nxt == 2'd1) || (w_phase_nxt == 2'd2);
        w_scl_nxt    = 1'b1;
        w_sda_oe_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE, ST_DONE: begin
                w_scl_nxt    = 1'b1;
                w_sda_oe_nxt = 1'b0;
            end
            ST_START: begin
                w_scl_nxt    = (w_phase_nxt != 2'd3);
                w_sda_oe_nxt = w_phase_nxt[1];
            end
            ST_RESTART: begin
                w_scl_nxt    = w_mid;
                w_sda_oe_nxt = w_phase_nxt[1];
            end
            ST_STOP: begin
                w_scl_nxt    = (w_phase_nxt != 2'd0);
                w_sda_oe_nxt = (w_phase_nxt != 2'd3);
            end
            ST_RX_DATA: begin
                // Slave drives data bits; bit 8 is the master NACK (released).
                w_scl_nxt    = w_mid;
                w_sda_oe_nxt = 1'b0;
            end
            default: begin
                // Transmit bits MSB first; bit 8 released for the slave ACK.
                w_scl_nxt    = w_mid;
                w_sda_oe_nxt = (w_bit_nxt != 4'd8) && !w_tx_byte[w_bit_idx];
            end
        endcase
    end

    // Main FSM register: state, captured request, sampled data and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= 2'd0;
            r_bit       <= 4'd0;
            r_rw        <= 1'b0;
            r_dev       <= 7'd0;
            r_mem       <= 8'd0;
            r_wdata     <= 8'd0;
            r_rx        <= 8'd0;
            r_sda_smp   <= 1'b0;
            r_rd_data   <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_bit    <= w_bit_nxt;
            r_scl    <= w_scl_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done   <= (w_state_nxt == ST_DONE);
            if ((r_state == ST_IDLE) && start) begin
                r_rw        <= rw;
                r_dev       <= dev_addr;
                r_mem       <= mem_addr;
                r_wdata     <= wr_data;
                r_ack_error <= 1'b0;
            end
            if (w_nack) begin
                r_ack_error <= 1'b1;
            end
            if (w_in_byte && (r_phase == 2'd2)) begin
                r_sda_smp <= sda_in;
                if ((r_state == ST_RX_DATA) && (r_bit != 4'd8)) begin
                    r_rx <= {r_rx[6:0], sda_in};
                end
            end
            if ((r_state == ST_STOP) && (w_state_nxt == ST_DONE) && r_rw && !r_ack_error) begin
                r_rd_data <= r_rx;
            end
        end
    end

endmodule

// File: doc/i2c_eeprom_master.md
Name: i2c_eeprom_master

Overview:
- Byte-level I2C master for 24Cxx-style EEPROMs with 8-bit word addresses.
- Sits directly downstream of the clock divider and is clocked by its divided output. The divider is configured for 4x the SCL rate, e.g. 400 kHz clock for 100 kHz SCL.
- Performs one single-byte write or one random read per start request, then reports result and completion to the controlling logic.

Parameters:
- None. Bus rate is set entirely by the upstream divider: SCL = clk_in/4.

Ports:
- clk_in  input  1  4x-SCL clock from clk_divider
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- rw  input  1  0 = byte write, 1 = random read; latched at start
- dev_addr  input  7  EEPROM device address; latched at start
- mem_addr  input  8  EEPROM word address; latched at start
- wr_data  input  8  byte to write; latched at start
- rd_data  output  8  byte read; updated only on successful read completion
- busy  output  1  high from first START cycle to last STOP cycle
- done  output  1  one-cycle pulse when a transaction ends (success or abort)
- ack_error  output  1  slave NACKed an address/data byte; held until next accepted start
- scl  output  1  I2C clock (1 = high/released)
- sda_oe  output  1  1 = pull SDA low, 0 = release (open drain)
- sda_in  input  1  SDA pin level

Behaviour:
- Reset (synchronous, active-high, every cycle while asserted):
  - State = IDLE; scl=1, sda_oe=0, busy=0, done=0, ack_error=0, rd_data=0.
  - Reset mid-transaction aborts immediately and releases both lines. No STOP is generated, no done pulse.
- Every bus element (START, RESTART, STOP, each bit) occupies 4 clocks, phases ph0..ph3. A 2-bit phase counter advances every cycle outside IDLE/DONE.
- Bit (write or read):
  - ph0: scl=0, sda_oe updated to the new bit (MSB first).
  - ph1 and ph2: scl=1.
  - ph2: sda_in sampled.
  - ph3: scl=0.
- START:
  - ph0/ph1: scl=1, sda released.
  - ph2: sda low, scl=1.
  - ph3: scl=0.
- RESTART:
  - ph0: scl=0, sda released.
  - ph1: scl=1.
  - ph2: sda low.
  - ph3: scl=0.
- STOP:
  - ph0: scl=0, sda low.
  - ph1/ph2: scl=1, sda low.
  - ph3: scl=1, sda released.
- Master ACK/NACK bit: master drives ACK = sda_oe 1 or NACK = sda_oe 0 during all four phases.
- Slave ACK bit: sda_oe=0 for all four phases; sda_in sampled at ph2 (0 = ACK).
- States:
  - IDLE → START on start=1. Inputs are latched and ack_error cleared in that same edge.
  - START → TX_DEVW: {dev_addr,0}, 8 bits + ACK → TX_MADDR: mem_addr + ACK.
  - Write: → TX_DATA: wr_data + ACK → STOP.
  - Read: → RESTART → TX_DEVR: {dev_addr,1} + ACK → RX_DATA: 8 bits sampled into a shift register, then master NACK → STOP.
  - STOP → DONE for one cycle: done=1, busy=0. On a successful read, rd_data is loaded in this cycle. → IDLE.
  - Slave NACK at any ACK bit: set ack_error, skip to STOP, then DONE. rd_data unchanged.
- Busy duration, from the cycle after start is accepted until done:
  - Write: 4+3×36+4 = 116 cycles.
  - Read: 4+2×36+4+2×36+4 = 156 cycles.
  - NACK on device address: 44 cycles.
- Boundaries:
  - start while busy or during DONE: ignored, not queued.
  - start asserted in the same cycle as DONE: ignored; accepted from IDLE next cycle.
  - start held high continuously: a new transaction begins on every return to IDLE.
  - Inputs changing mid-transaction have no effect.
  - sda_in only sampled at ph2 of ACK/RX bits; no arbitration or clock-stretch support.

Test Plan:
- Write dev=0x50, mem=0x12, data=0xA5, slave model ACKs all:
  - SDA sequence S, 0xA0 A, 0x12 A, 0xA5 A, P.
  - busy high exactly 116 cycles; done one pulse; ack_error=0.
- Random read dev=0x50, mem=0x34, slave returns 0x3C:
  - Sequence S, 0xA0 A, 0x34 A, Sr, 0xA1 A, 0x3C, master NACK, P.
  - rd_data=0x3C at done; busy 156 cycles.
- No slave present (sda_in stuck 1), write request:
  - STOP follows first ACK bit; ack_error=1; done after 44 cycles; rd_data unchanged.
- Slave NACKs the data byte of a write:
  - ack_error=1, STOP generated, busy 116 cycles.
  - Next start clears ack_error in the accept cycle.
- start pulsed at cycle 20 of a write, and start held high through done:
  - Mid-transaction pulse ignored.
  - Held start makes a second transaction begin two cycles after the done pulse (DONE→IDLE→START).
- reset asserted at cycle 50 of a read:
  - Next cycle scl=1, sda_oe=0, busy=0, no done pulse.
  - A subsequent start runs a full correct transaction.
